// File: rtl/noc_params.sv
// Router-wide constants and the port encoding shared by the NoC blocks.
package noc_params;
  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int BUFFER_SIZE = 8;
  localparam int CREDIT_W    = $clog2(BUFFER_SIZE + 1);
  localparam int PORT_W      = $clog2(PORT_NUM);

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;
endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the allocator and the crossbar.
interface switch_allocator_if;
  import noc_params::*;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              read_o;
  logic  [PORT_NUM-1:0][PORT_W-1:0]              input_sel_o;
  logic  [PORT_NUM-1:0]                          valid_o;
  logic                                          credit_err_o;

  modport master (
    output request_i, out_port_i, downstream_vc_i, credit_i,
    input  read_o, input_sel_o, valid_o, credit_err_o
  );

  modport slave (
    input  request_i, out_port_i, downstream_vc_i, credit_i,
    output read_o, input_sel_o, valid_o, credit_err_o
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a registered pointer;
// update_en_i moves the pointer just past the current winner.
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request_i,
  input  logic         update_en_i,
  output logic [N-1:0] grant_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic [PW-1:0] w_idx;

  // Scan from the far end back toward r_ptr so the closest requester wins last.
  always_comb begin
    grant_o = '0;
    w_next  = r_ptr;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if (request_i[w_idx]) begin
        grant_o        = '0;
        grant_o[w_idx] = 1'b1;
        w_next         = (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           r_ptr <= '0;
    else if (update_en_i && |grant_o)  r_ptr <= w_next;
  end
endmodule

// File: rtl/switch_allocator.sv
// Two-stage separable switch allocator (VC per input, then input per output)
// with per-output, per-VC downstream credit counters.
module switch_allocator
  import noc_params::*;
(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  sa
);
  logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_W-1:0] r_credit;
  logic                                          r_credit_err;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_elig, w_in_gnt, w_read, w_dec;
  logic  [PORT_NUM-1:0]               w_in_has, w_in_win, w_valid;
  port_t [PORT_NUM-1:0]               w_in_port;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_out_req, w_out_gnt;  // [output][input]
  logic  [PORT_NUM-1:0][PORT_W-1:0]   w_sel;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        if (sa.request_i[i][v] && int'(sa.out_port_i[i][v]) < PORT_NUM)
          w_elig[i][v] = r_credit[sa.out_port_i[i][v]][sa.downstream_vc_i[i][v]] != '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
      round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
        .clk         (clk),
        .rst         (rst),
        .request_i   (w_elig[gi]),
        .update_en_i (w_in_win[gi]),
        .grant_o     (w_in_gnt[gi])
      );
    end
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_out
      round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
        .clk         (clk),
        .rst         (rst),
        .request_i   (w_out_req[gi]),
        .update_en_i (w_valid[gi]),
        .grant_o     (w_out_gnt[gi])
      );
    end
  endgenerate

  // Stage-1 winner of each input is presented to the output it routes to.
  always_comb begin
    w_in_port = '{default: LOCAL};
    w_in_has  = '0;
    w_out_req = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++)
        if (w_in_gnt[i][v]) w_in_port[i] = sa.out_port_i[i][v];
      w_in_has[i] = |w_in_gnt[i];
      for (int o = 0; o < PORT_NUM; o++)
        w_out_req[o][i] = w_in_has[i] && (int'(w_in_port[i]) == o);
    end
  end

  always_comb begin
    w_in_win = '0;
    w_valid  = '0;
    w_sel    = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int i = 0; i < PORT_NUM; i++)
        if (w_out_gnt[o][i]) begin
          w_in_win[i] = 1'b1;
          w_valid[o]  = 1'b1;
          w_sel[o]    = PORT_W'(i);
        end
  end

  always_comb begin
    w_read = '0;
    w_dec  = '0;
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        if (w_in_gnt[i][v] && w_in_win[i]) begin
          w_read[i][v] = 1'b1;
          w_dec[sa.out_port_i[i][v]][sa.downstream_vc_i[i][v]] = 1'b1;
        end
  end

  // A return and a consume on the same counter cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++)
        for (int v = 0; v < VC_NUM; v++)
          r_credit[p][v] <= CREDIT_W'(BUFFER_SIZE);
      r_credit_err <= 1'b0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++)
        for (int v = 0; v < VC_NUM; v++)
          if (sa.credit_i[p][v] && !w_dec[p][v]) begin
            if (r_credit[p][v] == CREDIT_W'(BUFFER_SIZE)) r_credit_err <= 1'b1;
            else                                         r_credit[p][v] <= r_credit[p][v] + 1'b1;
          end else if (w_dec[p][v] && !sa.credit_i[p][v]) begin
            r_credit[p][v] <= r_credit[p][v] - 1'b1;
          end
    end
  end

  assign sa.read_o       = rst ? '0 : w_read;
  assign sa.valid_o      = rst ? '0 : w_valid;
  assign sa.input_sel_o  = rst ? '0 : w_sel;
  assign sa.credit_err_o = r_credit_err;
endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random
// traffic against a behavioural allocation/credit model.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_allocator_if sa_if();
  switch_allocator dut (.clk(clk), .rst(rst), .sa(sa_if));

  int errors = 0;
  int checks = 0;

  int m_cr [PORT_NUM][VC_NUM];
  int m_in_ptr [PORT_NUM];
  int m_out_ptr [PORT_NUM];
  bit m_err;

  logic [PORT_NUM-1:0][VC_NUM-1:0] e_read;
  logic [PORT_NUM-1:0]             e_valid;
  logic [PORT_NUM-1:0][PORT_W-1:0] e_sel;

  function automatic void model_reset();
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) m_cr[p][v] = BUFFER_SIZE;
      m_in_ptr[p] = 0;
      m_out_ptr[p] = 0;
    end
    m_err = 1'b0;
  endfunction

  // Expected grants for the current inputs and model state.
  function automatic void predict();
    int w [PORT_NUM];
    int v, i, op, dv;
    e_read = '0; e_valid = '0; e_sel = '0;
    if (rst) return;
    for (int a = 0; a < PORT_NUM; a++) begin
      w[a] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        v  = (m_in_ptr[a] + k) % VC_NUM;
        op = int'(sa_if.out_port_i[a][v]);
        dv = int'(sa_if.downstream_vc_i[a][v]);
        if (w[a] < 0 && sa_if.request_i[a][v] && op < PORT_NUM && m_cr[op][dv] > 0) w[a] = v;
      end
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int k = 0; k < PORT_NUM; k++) begin
        i = (m_out_ptr[o] + k) % PORT_NUM;
        if (!e_valid[o] && w[i] >= 0 && int'(sa_if.out_port_i[i][w[i]]) == o) begin
          e_valid[o] = 1'b1;
          e_sel[o] = PORT_W'(i);
          e_read[i][w[i]] = 1'b1;
        end
      end
  endfunction

  // Clock edge: advance the model using the grants predicted for this cycle.
  task automatic tick();
    bit dec [PORT_NUM][VC_NUM];
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int p = 0; p < PORT_NUM; p++)
        for (int v = 0; v < VC_NUM; v++) dec[p][v] = 1'b0;
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++)
          if (e_read[i][v]) begin
            dec[int'(sa_if.out_port_i[i][v])][int'(sa_if.downstream_vc_i[i][v])] = 1'b1;
            m_in_ptr[i] = (v + 1) % VC_NUM;
          end
      for (int o = 0; o < PORT_NUM; o++)
        if (e_valid[o]) m_out_ptr[o] = (int'(e_sel[o]) + 1) % PORT_NUM;
      for (int p = 0; p < PORT_NUM; p++)
        for (int v = 0; v < VC_NUM; v++) begin
          if (sa_if.credit_i[p][v] && dec[p][v]) ;
          else if (sa_if.credit_i[p][v]) begin
            if (m_cr[p][v] == BUFFER_SIZE) m_err = 1'b1;
            else m_cr[p][v]++;
          end else if (dec[p][v]) m_cr[p][v]--;
        end
    end
    #1;
  endtask

  task automatic clear_inputs();
    sa_if.request_i = '0;
    sa_if.out_port_i = '{default: LOCAL};
    sa_if.downstream_vc_i = '0;
    sa_if.credit_i = '0;
  endtask

  task automatic set_req(input int i, input int v, input port_t o, input int dv);
    sa_if.request_i[i][v] = 1'b1;
    sa_if.out_port_i[i][v] = o;
    sa_if.downstream_vc_i[i][v] = VC_SIZE'(dv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); predict(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_req(1, 0, EAST, 0);
    rst = 1'b1;
    @(negedge clk); predict();
    checks++;
    if (sa_if.read_o !== '0 || sa_if.valid_o !== '0 || sa_if.input_sel_o !== '0) begin
      errors++; $display("FAIL reset_outputs read=%h valid=%b sel=%h exp all zero",
                         sa_if.read_o, sa_if.valid_o, sa_if.input_sel_o);
    end
    tick();
    rst = 1'b0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) begin
        checks++;
        if (dut.r_credit[p][v] !== CREDIT_W'(8)) begin
          errors++; $display("FAIL reset_credit[%0d][%0d] got=%0d exp=8", p, v, dut.r_credit[p][v]);
        end
      end
    checks++;
    if (sa_if.credit_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", sa_if.credit_err_o);
    end
  endtask

  task automatic test_single();
    logic [PORT_NUM-1:0][VC_NUM-1:0] x;
    x = '0; x[1][0] = 1'b1;
    @(negedge clk); predict();
    checks++;
    if (sa_if.read_o !== x || sa_if.valid_o !== 5'b10000 || sa_if.input_sel_o[4] !== 3'd1) begin
      errors++; $display("FAIL single_grant read=%h valid=%b sel4=%0d exp read=%h valid=10000 sel4=1",
                         sa_if.read_o, sa_if.valid_o, sa_if.input_sel_o[4], x);
    end
    tick();
    checks++;
    if (dut.r_credit[4][0] !== CREDIT_W'(7)) begin
      errors++; $display("FAIL single_credit got=%0d exp=7", dut.r_credit[4][0]);
    end
  endtask

  task automatic test_exhaust();
    clear_inputs(); do_reset();
    set_req(1, 0, EAST, 0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); predict();
      checks++;
      if (sa_if.valid_o[4] !== (c < 8) || sa_if.read_o !== e_read) begin
        errors++; $display("FAIL exhaust_cyc%0d valid4=%b exp=%b read=%h exp=%h",
                           c + 1, sa_if.valid_o[4], (c < 8), sa_if.read_o, e_read);
      end
      tick();
    end
    sa_if.credit_i[4][0] = 1'b1;
    @(negedge clk); predict();
    checks++;
    if (sa_if.valid_o !== '0) begin
      errors++; $display("FAIL exhaust_credit_cycle valid=%b exp=00000", sa_if.valid_o);
    end
    tick();
    sa_if.credit_i[4][0] = 1'b0;
    @(negedge clk); predict();
    checks++;
    if (sa_if.valid_o !== 5'b10000 || sa_if.input_sel_o[4] !== 3'd1) begin
      errors++; $display("FAIL exhaust_regrant valid=%b sel4=%0d exp valid=10000 sel4=1",
                         sa_if.valid_o, sa_if.input_sel_o[4]);
    end
    tick();
  endtask

  task automatic contention_setup();
    clear_inputs();
    for (int i = 0; i < 4; i++) set_req(i, 0, EAST, 0);
    sa_if.credit_i[4][0] = 1'b1;
  endtask

  task automatic test_contention();
    clear_inputs(); do_reset();
    contention_setup();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); predict();
      checks++;
      if (sa_if.valid_o !== 5'b10000 || sa_if.input_sel_o[4] !== PORT_W'(c % 4)
          || sa_if.read_o !== e_read) begin
        errors++; $display("FAIL contention_cyc%0d valid=%b sel4=%0d exp valid=10000 sel4=%0d",
                           c, sa_if.valid_o, sa_if.input_sel_o[4], c % 4);
      end
      tick();
    end
    checks++;
    if (sa_if.credit_err_o !== 1'b0) begin
      errors++; $display("FAIL contention_err got=%b exp=0", sa_if.credit_err_o);
    end
  endtask

  task automatic test_vc_fair();
    clear_inputs(); do_reset();
    set_req(3, 0, SOUTH, 0);
    set_req(3, 1, SOUTH, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); predict();
      checks++;
      if (sa_if.read_o[3] !== ((c % 2 == 0) ? 2'b01 : 2'b10) || sa_if.input_sel_o[2] !== 3'd3) begin
        errors++; $display("FAIL vcfair_cyc%0d read3=%b sel2=%0d exp read3=%b sel2=3",
                           c, sa_if.read_o[3], sa_if.input_sel_o[2], (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    set_req(0, 0, SOUTH, 0);
    @(negedge clk); predict();
    checks++;
    if (sa_if.input_sel_o[2] !== 3'd0 || sa_if.read_o[3] !== 2'b00 || sa_if.read_o[0] !== 2'b01) begin
      errors++; $display("FAIL vcfair_lose sel2=%0d read3=%b read0=%b exp sel2=0 read3=00 read0=01",
                         sa_if.input_sel_o[2], sa_if.read_o[3], sa_if.read_o[0]);
    end
    tick();
    @(negedge clk); predict();
    checks++;
    if (sa_if.input_sel_o[2] !== 3'd3 || sa_if.read_o[3] !== 2'b10) begin
      errors++; $display("FAIL vcfair_keep_ptr sel2=%0d read3=%b exp sel2=3 read3=10",
                         sa_if.input_sel_o[2], sa_if.read_o[3]);
    end
    tick();
  endtask

  task automatic test_credit_arith();
    clear_inputs(); do_reset();
    set_req(1, 1, EAST, 1);
    for (int c = 0; c < 5; c++) begin @(negedge clk); predict(); tick(); end
    checks++;
    if (dut.r_credit[4][1] !== CREDIT_W'(3)) begin
      errors++; $display("FAIL arith_drain got=%0d exp=3", dut.r_credit[4][1]);
    end
    sa_if.credit_i[4][1] = 1'b1;
    @(negedge clk); predict();
    checks++;
    if (sa_if.valid_o[4] !== 1'b1) begin
      errors++; $display("FAIL arith_simul_grant valid4=%b exp=1", sa_if.valid_o[4]);
    end
    tick();
    checks++;
    if (dut.r_credit[4][1] !== CREDIT_W'(3)) begin
      errors++; $display("FAIL arith_simul got=%0d exp=3", dut.r_credit[4][1]);
    end
    sa_if.request_i = '0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); predict(); tick(); end
    checks++;
    if (dut.r_credit[4][1] !== CREDIT_W'(8) || sa_if.credit_err_o !== 1'b0) begin
      errors++; $display("FAIL arith_refill credit=%0d err=%b exp credit=8 err=0",
                         dut.r_credit[4][1], sa_if.credit_err_o);
    end
    @(negedge clk); predict(); tick();
    sa_if.credit_i = '0;
    checks++;
    if (dut.r_credit[4][1] !== CREDIT_W'(8) || sa_if.credit_err_o !== 1'b1) begin
      errors++; $display("FAIL arith_overflow credit=%0d err=%b exp credit=8 err=1",
                         dut.r_credit[4][1], sa_if.credit_err_o);
    end
    for (int c = 0; c < 3; c++) begin @(negedge clk); predict(); tick(); end
    checks++;
    if (sa_if.credit_err_o !== 1'b1) begin
      errors++; $display("FAIL arith_sticky err=%b exp=1", sa_if.credit_err_o);
    end
    do_reset();
    checks++;
    if (sa_if.credit_err_o !== 1'b0) begin
      errors++; $display("FAIL arith_err_clear err=%b exp=0", sa_if.credit_err_o);
    end
  endtask

  task automatic test_mid_reset();
    clear_inputs(); do_reset();
    contention_setup();
    sa_if.credit_i = '0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); predict(); tick(); end
    rst = 1'b1;
    @(negedge clk); predict();
    checks++;
    if (sa_if.valid_o !== '0 || sa_if.read_o !== '0 || sa_if.input_sel_o !== '0) begin
      errors++; $display("FAIL midreset_outputs read=%h valid=%b exp zero", sa_if.read_o, sa_if.valid_o);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (dut.r_credit[4][0] !== CREDIT_W'(8)) begin
      errors++; $display("FAIL midreset_credit got=%0d exp=8", dut.r_credit[4][0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); predict();
      checks++;
      if (sa_if.valid_o !== 5'b10000 || sa_if.input_sel_o[4] !== PORT_W'(c)) begin
        errors++; $display("FAIL midreset_rotate%0d valid=%b sel4=%0d exp sel4=%0d",
                           c, sa_if.valid_o, sa_if.input_sel_o[4], c);
      end
      tick();
    end
  endtask

  task automatic test_random();
    clear_inputs(); do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++) begin
          sa_if.request_i[i][v] = ($urandom_range(0, 2) != 0);
          sa_if.out_port_i[i][v] = port_t'(3'($urandom_range(0, 4)));
          sa_if.downstream_vc_i[i][v] = VC_SIZE'($urandom_range(0, VC_NUM - 1));
          sa_if.credit_i[i][v] = ($urandom_range(0, 3) == 0);
        end
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk); predict();
      checks++;
      if (sa_if.read_o !== e_read || sa_if.valid_o !== e_valid || sa_if.input_sel_o !== e_sel
          || sa_if.credit_err_o !== m_err) begin
        errors++; $display("FAIL random_cyc%0d read=%h/%h valid=%b/%b sel=%h/%h err=%b/%b (got/exp)",
                           c, sa_if.read_o, e_read, sa_if.valid_o, e_valid,
                           sa_if.input_sel_o, e_sel, sa_if.credit_err_o, m_err);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_single();
    test_exhaust();
    test_contention();
    test_vc_fair();
    test_credit_arith();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
